// File: rtl/logical_pkg.sv
// Shared types and helpers for the logical-operator family.
package logical_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } snot_state_t;

  // Bit-counter width for an n-bit serial scan.
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/serial_logical_not.sv
// Bit-serial zero detect: accepts an N-bit operand, scans it LSB first one
// bit per clock and returns c = ~|a over a valid/ready handshake.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | a_ready high, waiting for an operand
//   SCAN  | shifting the operand out of sh, OR-ing each bit into acc
//   DONE  | result held on c with c_valid high until c_ready
module serial_logical_not
  import logical_pkg::*;
#(
  parameter int N          = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [N-1:0] a,
  output logic         c_valid,
  input  logic         c_ready,
  output logic         c,
  output logic         busy
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  snot_state_t   state, state_nx;
  logic [N-1:0]  sh, sh_nx;
  logic          acc, acc_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          c_q, c_nx;
  logic          acc_scan;
  logic          scan_exit;

  // State, datapath and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh    <= '0;
      acc   <= 1'b0;
      cnt   <= '0;
      c_q   <= 1'b0;
    end else begin
      state <= state_nx;
      sh    <= sh_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
      c_q   <= c_nx;
    end
  end

  // Next-state and datapath update; everything holds unless the state acts.
  always_comb begin
    state_nx  = state;
    sh_nx     = sh;
    acc_nx    = acc;
    cnt_nx    = cnt;
    c_nx      = c_q;
    acc_scan  = acc | sh[0];
    scan_exit = (cnt == CNT_LAST) || (EARLY_EXIT && sh[0]);
    case (state)
      IDLE: begin
        if (a_valid) begin
          sh_nx    = a;
          acc_nx   = 1'b0;
          cnt_nx   = '0;
          state_nx = SCAN;
        end
      end
      SCAN: begin
        acc_nx = acc_scan;
        sh_nx  = sh >> 1;
        // cnt may wrap on the exit edge; it is reloaded on the next acceptance.
        cnt_nx = cnt + CW'(1);
        if (scan_exit) begin
          c_nx     = ~acc_scan;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (c_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign a_ready = (state == IDLE);
  assign c_valid = (state == DONE);
  assign busy    = (state != IDLE);
  assign c       = c_q;

endmodule

// File: tb/tb_serial_logical_not.sv
// Directed and random checks of serial_logical_not across widths and
// early-exit settings.
module tb_serial_logical_not;

  logic        clk;
  logic        rst_n;
  logic [3:0]  a_valid;
  logic [3:0]  c_ready;
  logic [12:0] a_in [4];
  logic [3:0]  a_ready;
  logic [3:0]  c_valid;
  logic [3:0]  c_out;
  logic [3:0]  busy;

  int checks = 0;
  int errors = 0;

  // Instance configurations: width and early-exit per index.
  int          cfg_n  [4] = '{8, 8, 13, 2};
  logic        cfg_ee [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_logical_not #(.N(8), .EARLY_EXIT(1'b0)) u_n8_fix (
    .clk(clk), .rst_n(rst_n), .a_valid(a_valid[0]), .a_ready(a_ready[0]),
    .a(a_in[0][7:0]), .c_valid(c_valid[0]), .c_ready(c_ready[0]),
    .c(c_out[0]), .busy(busy[0]));

  serial_logical_not #(.N(8), .EARLY_EXIT(1'b1)) u_n8_ee (
    .clk(clk), .rst_n(rst_n), .a_valid(a_valid[1]), .a_ready(a_ready[1]),
    .a(a_in[1][7:0]), .c_valid(c_valid[1]), .c_ready(c_ready[1]),
    .c(c_out[1]), .busy(busy[1]));

  serial_logical_not #(.N(13), .EARLY_EXIT(1'b1)) u_n13_ee (
    .clk(clk), .rst_n(rst_n), .a_valid(a_valid[2]), .a_ready(a_ready[2]),
    .a(a_in[2][12:0]), .c_valid(c_valid[2]), .c_ready(c_ready[2]),
    .c(c_out[2]), .busy(busy[2]));

  serial_logical_not #(.N(2), .EARLY_EXIT(1'b0)) u_n2_fix (
    .clk(clk), .rst_n(rst_n), .a_valid(a_valid[3]), .a_ready(a_ready[3]),
    .a(a_in[3][1:0]), .c_valid(c_valid[3]), .c_ready(c_ready[3]),
    .c(c_out[3]), .busy(busy[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected latency from the acceptance edge, derived from the operand.
  function automatic int exp_lat(input logic [12:0] val, input int n, input logic ee);
    if (!ee) return n;
    for (int i = 0; i < n; i++) begin
      if (val[i]) return i + 1;
    end
    return n;
  endfunction

  function automatic logic [12:0] mask_n(input logic [12:0] val, input int n);
    logic [12:0] m;
    m = (13'd1 << n) - 13'd1;
    return val & m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One directed operand; hold = number of cycles c_ready stays low after c_valid.
  task automatic run_op(input int idx, input logic [12:0] val, input int lat,
                        input logic expc, input int hold);
    int n;
    a_in[idx]    = val;
    a_valid[idx] = 1'b1;
    c_ready[idx] = (hold == 0);
    tick();
    a_valid[idx] = 1'b0;
    check("busy_after_accept", 32'(busy[idx]), 32'd1);
    check("a_ready_low_scan", 32'(a_ready[idx]), 32'd0);
    n = 0;
    while (!c_valid[idx] && n < 40) begin
      tick();
      n++;
    end
    check("latency", n, lat);
    check("c_value", 32'(c_out[idx]), 32'(expc));
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        a_valid[idx] = 1'b1;
        a_in[idx]    = ~val;
        tick();
        check("hold_c_valid", 32'(c_valid[idx]), 32'd1);
        check("hold_c", 32'(c_out[idx]), 32'(expc));
        check("hold_a_ready", 32'(a_ready[idx]), 32'd0);
      end
      a_valid[idx] = 1'b0;
      c_ready[idx] = 1'b1;
    end
    tick();
    check("c_valid_drop", 32'(c_valid[idx]), 32'd0);
    check("a_ready_back", 32'(a_ready[idx]), 32'd1);
  endtask

  // Random operand with random gap and random consumer backpressure.
  task automatic rand_op(input int idx);
    logic [12:0] val;
    int  n, lat_e, cyc;
    bit  seen, done, hs;
    logic expc;
    n   = cfg_n[idx];
    val = mask_n(13'($urandom), n);
    if ($urandom_range(0, 3) == 0) val = '0;
    lat_e = exp_lat(val, n, cfg_ee[idx]);
    expc  = (val == '0);
    repeat ($urandom_range(0, 3)) tick();
    a_in[idx]    = val;
    a_valid[idx] = 1'b1;
    c_ready[idx] = 1'($urandom_range(0, 1));
    tick();
    a_valid[idx] = 1'b0;
    a_in[idx]    = 13'($urandom);
    cyc  = 0;
    seen = 1'b0;
    done = 1'b0;
    while (!done && cyc < 60) begin
      c_ready[idx] = 1'($urandom_range(0, 1));
      hs = c_valid[idx] && c_ready[idx];
      tick();
      cyc++;
      if (hs) begin
        done = 1'b1;
      end else if (c_valid[idx] && !seen) begin
        seen = 1'b1;
        check("rnd_latency", cyc, lat_e);
        check("rnd_c", 32'(c_out[idx]), 32'(expc));
      end else if (c_valid[idx]) begin
        check("rnd_c_stable", 32'(c_out[idx]), 32'(expc));
      end
    end
    check("rnd_completed", 32'(done), 32'd1);
    check("rnd_no_dup", 32'(c_valid[idx]), 32'd0);
    c_ready[idx] = 1'b0;
  endtask

  initial begin
    int n;
    bit spur;
    rst_n   = 1'b0;
    a_valid = '0;
    c_ready = '0;
    for (int i = 0; i < 4; i++) a_in[i] = '0;
    #12;
    check("rst_a_ready", 32'(a_ready), 32'hF);
    check("rst_c_valid", 32'(c_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_c", 32'(c_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset mid-scan discards the operand immediately.
    a_in[0]    = 13'h00;
    a_valid[0] = 1'b1;
    c_ready[0] = 1'b1;
    tick();
    a_valid[0] = 1'b0;
    tick();
    tick();
    check("midscan_busy", 32'(busy[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_a_ready", 32'(a_ready[0]), 32'd1);
    check("async_c_valid", 32'(c_valid[0]), 32'd0);
    check("async_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    spur = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (c_valid[0] || busy[0]) spur = 1'b1;
    end
    check("no_result_after_reset", 32'(spur), 32'd0);
    c_ready[0] = 1'b0;

    // Fixed latency, N=8.
    run_op(0, 13'h00, 8, 1'b1, 0);
    run_op(0, 13'h01, 8, 1'b0, 0);
    run_op(0, 13'h80, 8, 1'b0, 0);

    // Early exit, N=8.
    run_op(1, 13'h04, 3, 1'b0, 0);
    run_op(1, 13'h80, 8, 1'b0, 0);
    run_op(1, 13'h01, 1, 1'b0, 0);
    run_op(1, 13'h00, 8, 1'b1, 0);

    // Backpressure for 5 cycles.
    run_op(1, 13'h10, 5, 1'b0, 5);
    run_op(0, 13'h00, 8, 1'b1, 5);

    // Boundary widths.
    run_op(2, 13'h1000, 13, 1'b0, 0);
    run_op(2, 13'h0000, 13, 1'b1, 0);
    run_op(3, 13'h0, 2, 1'b1, 0);
    run_op(3, 13'h2, 2, 1'b0, 0);

    // Random sweep across N = 8, 13, 2.
    for (int k = 0; k < 1000; k++) begin
      rand_op(1 + (k % 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time guard so the run always terminates.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not reach the end");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
